bbus_seq: RTL and testbench
===========================

# bbus_seq

Bus sequencer and arbiter for the shared chip bus (bd, brd_n, bwr_n) between the W5300 and SL811 chips. It accepts transactions from two requesters: r0, the Z80 decode path, and r1, the auxiliary/poller path. Round-robin arbitration decides between them. Each granted transaction runs as setup/strobe/hold phases counted in fclk cycles, with the strobe length set per target chip. It returns read data with a one-cycle ack.

## Interface
Parameters:
- SETUP, 2, cycles from CS/address/data valid to strobe asserted (1..15)
- STROBE_W, 4, brd_n/bwr_n low time for W5300 (1..15)
- STROBE_S, 3, brd_n/bwr_n low time for SL811 (1..15)
- HOLD, 1, cycles from strobe negated to CS negated (1..15)

Ports:
- fclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rN_req  in  1  request, N=0,1; held high until ack
- rN_rnw  in  1  1=read, 0=write
- rN_tgt  in  1  0=W5300, 1=SL811
- rN_addr  in  10  W5300 address; bit 0 is the SL811 a0
- rN_wdata  in  8  write data
- rN_ack  out  1  one-cycle completion pulse
- rdata  out  8  read data, shared by both requesters; valid while ack is high and held until the next read
- w5300_addr  out  10  W5300 address
- w5300_cs_n  out  1  W5300 chip select
- sl811_a0  out  1  SL811 a0
- sl811_cs_n  out  1  SL811 chip select
- brd_n, bwr_n  out  1  bus strobes
- bd_out  out  8  bus write data
- bd_oe  out  1  bus output enable
- bd_in  in  8  bus read data
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs are registered.
- Reset values:
  - cs_n, brd_n, bwr_n = 1
  - bd_oe = 0; acks = 0; busy = 0
  - w5300_addr, sl811_a0, bd_out, rdata = 0
  - last-grant = r1, so r0 wins the first tie
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A 4-bit down-counter is loaded on entry to each phase.
- IDLE:
  - If any req is high, grant. If only one is high, grant it. If both are high, grant the requester not granted last, then update last-grant.
  - Latch rnw, tgt, addr and wdata of the granted requester, then go to SETUP.
- SETUP (SETUP cycles):
  - The selected target's CS is low and address is driven.
  - For writes, bd_out = wdata and bd_oe = 1.
  - The other CS stays high; both chip selects are never low together.
- STROBE (STROBE_W or STROBE_S cycles, chosen by tgt): brd_n low for reads, bwr_n low for writes.
  - On the last STROBE cycle, rdata <= bd_in for reads.
- HOLD (HOLD cycles):
  - Both strobes are high; CS, address and bd_oe are unchanged.
  - The granted requester's ack pulses on the first HOLD cycle.
- Return to IDLE: CS high, bd_oe = 0.
- Requester rule: drop req, or present the next transaction, on the edge where ack is sampled. A req still high in IDLE is treated as a new transaction.
- A requester that is not granted waits with req held. Its fields must stay stable until its ack.
- rst high in any state forces reset values on the next edge. The in-flight transaction is abandoned and no ack is issued.
- Arbitration is evaluated only in IDLE. A request arriving mid-transaction waits.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- SETUP occupies cycles 1..SETUP.
- STROBE occupies cycles SETUP+1..SETUP+T, where T = STROBE_W or STROBE_S.
- ack falls in cycle SETUP+T+1.
- IDLE resumes at cycle SETUP+T+HOLD+1.
- With default parameters:
  - W5300: CS low in cycles 1..7, strobe low in 3..6, ack in 7, IDLE in 8.
  - SL811: CS low in 1..6, strobe low in 3..5, ack in 6, IDLE in 7.
- Back-to-back transactions have exactly one IDLE cycle between them, in which CS is high for at least 1 cycle.
- Throughput is one transaction per SETUP+T+HOLD+1 cycles.

## Structure
- Package bbus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - TGT_W5300 = 0, TGT_SL811 = 1
  - 4-bit phase counter width
- Sub-module bbus_rr_arb: 2-way round-robin.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot grant and the last-grant flop.
- Phase counter and FSM live in bbus_seq.

## Test plan
- Reset: assert rst for 3 cycles. All outputs must be at reset values, with busy = 0 and both acks = 0.
- r0 write to W5300, addr 0x2A5, data 0x5C:
  - w5300_cs_n low in cycles 1..7; bwr_n low in 3..6.
  - bd_out = 0x5C with bd_oe = 1 in 1..7.
  - r0_ack in 7; sl811_cs_n stays 1 throughout.
- r1 read from SL811, addr bit 0 = 1, bd_in = 0xA7:
  - sl811_a0 = 1; brd_n low in 3..5.
  - r1_ack with rdata = 0xA7 in cycle 6; bd_oe stays 0.
- r0 and r1 both held high for 3 transactions: grants go r0, r1, r0. Each ack goes only to the granted requester, and there is one IDLE cycle between transactions.
- rst pulsed in the second STROBE cycle of a W5300 read: next cycle brd_n = 1, cs_n = 1, no ack. A fresh r1 request afterwards completes normally with the default timing.
- Parameters STROBE_W = 1, HOLD = 1, SETUP = 1: W5300 write has bwr_n low in cycle 2 only, ack in 3, and IDLE in 4.

Source files
------------

// File: rtl/bbus_pkg.sv
// ---------------------------------------------------------------------------
// bbus_pkg : shared types and constants for the W5300/SL811 bus sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic TGT_W5300 = 1'b0;
    localparam logic TGT_SL811 = 1'b1;

    localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/bbus_rr_arb.sv
// ---------------------------------------------------------------------------
// bbus_rr_arb : two-way round-robin arbiter with last-grant flop
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bbus_rr_arb (
    input  logic       fclk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       last_o
);

    logic r_last_q;
    logic r_last_d;

    // On a tie the requester not granted last wins; reset value 1 favours r0.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = r_last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        r_last_d = r_last_q;
        if (advance_i && (grant_o != 2'b00)) begin
            r_last_d = grant_o[1];
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_last_q <= 1'b1;
        end else begin
            r_last_q <= r_last_d;
        end
    end

    assign last_o = r_last_q;

endmodule

`default_nettype wire

// File: rtl/bbus_seq.sv
// ---------------------------------------------------------------------------
// bbus_seq : setup/strobe/hold sequencer for the shared W5300/SL811 bus
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bbus_seq
    import bbus_pkg::*;
#(
    parameter int SETUP    = 2,
    parameter int STROBE_W = 4,
    parameter int STROBE_S = 3,
    parameter int HOLD     = 1
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       r0_req,
    input  logic       r0_rnw,
    input  logic       r0_tgt,
    input  logic [9:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_ack,
    input  logic       r1_req,
    input  logic       r1_rnw,
    input  logic       r1_tgt,
    input  logic [9:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_ack,
    output logic [7:0] rdata,
    output logic [9:0] w5300_addr,
    output logic       w5300_cs_n,
    output logic       sl811_a0,
    output logic       sl811_cs_n,
    output logic       brd_n,
    output logic       bwr_n,
    output logic [7:0] bd_out,
    output logic       bd_oe,
    input  logic [7:0] bd_in,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_SETUP_LD = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] c_STW_LD   = CNT_W'(STROBE_W - 1);
    localparam logic [CNT_W-1:0] c_STS_LD   = CNT_W'(STROBE_S - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LD  = CNT_W'(HOLD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rnw_q, rnw_d;
    logic               tgt_q, tgt_d;
    logic [9:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;

    logic               r0_ack_q, r0_ack_d;
    logic               r1_ack_q, r1_ack_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [9:0]         w5300_addr_q, w5300_addr_d;
    logic               w5300_cs_n_q, w5300_cs_n_d;
    logic               sl811_a0_q, sl811_a0_d;
    logic               sl811_cs_n_q, sl811_cs_n_d;
    logic               brd_n_q, brd_n_d;
    logic               bwr_n_q, bwr_n_d;
    logic [7:0]         bd_out_q, bd_out_d;
    logic               bd_oe_q, bd_oe_d;
    logic               busy_q, busy_d;

    logic [1:0]         w_grant;
    logic               w_last;
    logic               w_advance;

    bbus_rr_arb u_arb (
        .fclk      (fclk),
        .rst       (rst),
        .req_i     ({r1_req, r0_req}),
        .advance_i (w_advance),
        .grant_o   (w_grant),
        .last_o    (w_last)
    );

    // Phase sequencing; each phase counter is loaded with its length minus one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rnw_d     = rnw_q;
        tgt_d     = tgt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        w_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    w_advance = 1'b1;
                    state_d   = ST_SETUP;
                    cnt_d     = c_SETUP_LD;
                    if (w_grant[0]) begin
                        rnw_d   = r0_rnw;
                        tgt_d   = r0_tgt;
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end else begin
                        rnw_d   = r1_rnw;
                        tgt_d   = r1_tgt;
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = (tgt_q == TGT_SL811) ? c_STS_LD : c_STW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = c_HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so every pin comes straight off a flop.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        w5300_cs_n_d = !(busy_d && (tgt_d == TGT_W5300));
        sl811_cs_n_d = !(busy_d && (tgt_d == TGT_SL811));
        bd_oe_d      = busy_d && !rnw_d;
        brd_n_d      = !((state_d == ST_STROBE) && rnw_d);
        bwr_n_d      = !((state_d == ST_STROBE) && !rnw_d);
        w5300_addr_d = w5300_addr_q;
        sl811_a0_d   = sl811_a0_q;
        bd_out_d     = bd_out_q;
        rdata_d      = rdata_q;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
        if (w_advance) begin
            if (tgt_d == TGT_W5300) begin
                w5300_addr_d = addr_d;
            end else begin
                sl811_a0_d = addr_d[0];
            end
            if (!rnw_d) begin
                bd_out_d = wdata_d;
            end
        end
        if ((state_q == ST_STROBE) && (cnt_q == '0)) begin
            if (rnw_q) begin
                rdata_d = bd_in;
            end
            // The arbiter's last-grant flop names the requester in flight.
            r0_ack_d = !w_last;
            r1_ack_d = w_last;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rnw_q        <= 1'b1;
            tgt_q        <= TGT_W5300;
            addr_q       <= '0;
            wdata_q      <= '0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            rdata_q      <= '0;
            w5300_addr_q <= '0;
            w5300_cs_n_q <= 1'b1;
            sl811_a0_q   <= 1'b0;
            sl811_cs_n_q <= 1'b1;
            brd_n_q      <= 1'b1;
            bwr_n_q      <= 1'b1;
            bd_out_q     <= '0;
            bd_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rnw_q        <= rnw_d;
            tgt_q        <= tgt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            rdata_q      <= rdata_d;
            w5300_addr_q <= w5300_addr_d;
            w5300_cs_n_q <= w5300_cs_n_d;
            sl811_a0_q   <= sl811_a0_d;
            sl811_cs_n_q <= sl811_cs_n_d;
            brd_n_q      <= brd_n_d;
            bwr_n_q      <= bwr_n_d;
            bd_out_q     <= bd_out_d;
            bd_oe_q      <= bd_oe_d;
            busy_q       <= busy_d;
        end
    end

    assign r0_ack     = r0_ack_q;
    assign r1_ack     = r1_ack_q;
    assign rdata      = rdata_q;
    assign w5300_addr = w5300_addr_q;
    assign w5300_cs_n = w5300_cs_n_q;
    assign sl811_a0   = sl811_a0_q;
    assign sl811_cs_n = sl811_cs_n_q;
    assign brd_n      = brd_n_q;
    assign bwr_n      = bwr_n_q;
    assign bd_out     = bd_out_q;
    assign bd_oe      = bd_oe_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bbus_seq.sv
// ---------------------------------------------------------------------------
// tb_bbus_seq : directed bench for bbus_seq (default and short-timing builds)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bbus_seq;

    logic       fclk = 1'b0;
    logic       rst;
    logic       r0_req, r0_rnw, r0_tgt;
    logic [9:0] r0_addr;
    logic [7:0] r0_wdata;
    logic       r1_req, r1_rnw, r1_tgt;
    logic [9:0] r1_addr;
    logic [7:0] r1_wdata;
    logic [7:0] bd_in;

    logic       r0_ack, r1_ack, w5300_cs_n, sl811_a0, sl811_cs_n, brd_n, bwr_n, bd_oe, busy;
    logic [7:0] rdata, bd_out;
    logic [9:0] w5300_addr;

    logic       b_r0_ack, b_r1_ack, b_w5300_cs_n, b_sl811_a0, b_sl811_cs_n;
    logic       b_brd_n, b_bwr_n, b_bd_oe, b_busy;
    logic [7:0] b_rdata, b_bd_out;
    logic [9:0] b_w5300_addr;

    int checks = 0;
    int errors = 0;

    always #5 fclk = ~fclk;

    bbus_seq dut (
        .fclk(fclk), .rst(rst),
        .r0_req(r0_req), .r0_rnw(r0_rnw), .r0_tgt(r0_tgt), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_rnw(r1_rnw), .r1_tgt(r1_tgt), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .w5300_addr(w5300_addr), .w5300_cs_n(w5300_cs_n),
        .sl811_a0(sl811_a0), .sl811_cs_n(sl811_cs_n), .brd_n(brd_n), .bwr_n(bwr_n),
        .bd_out(bd_out), .bd_oe(bd_oe), .bd_in(bd_in), .busy(busy)
    );

    bbus_seq #(.SETUP(1), .STROBE_W(1), .STROBE_S(3), .HOLD(1)) dut_b (
        .fclk(fclk), .rst(rst),
        .r0_req(r0_req), .r0_rnw(r0_rnw), .r0_tgt(r0_tgt), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(b_r0_ack),
        .r1_req(r1_req), .r1_rnw(r1_rnw), .r1_tgt(r1_tgt), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(b_r1_ack),
        .rdata(b_rdata), .w5300_addr(b_w5300_addr), .w5300_cs_n(b_w5300_cs_n),
        .sl811_a0(b_sl811_a0), .sl811_cs_n(b_sl811_cs_n), .brd_n(b_brd_n), .bwr_n(b_bwr_n),
        .bd_out(b_bd_out), .bd_oe(b_bd_oe), .bd_in(bd_in), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and settle just after the edge.
    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    initial begin
        bit in_rng;
        int guard;

        rst = 1'b1;
        r0_req = 0; r0_rnw = 1; r0_tgt = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_rnw = 1; r1_tgt = 0; r1_addr = '0; r1_wdata = '0;
        bd_in = 8'h00;

        // Reset held for three cycles
        repeat (3) step();
        check("rst_w5300_cs_n", w5300_cs_n, 1);
        check("rst_sl811_cs_n", sl811_cs_n, 1);
        check("rst_brd_n", brd_n, 1);
        check("rst_bwr_n", bwr_n, 1);
        check("rst_bd_oe", bd_oe, 0);
        check("rst_acks", {r1_ack, r0_ack}, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", w5300_addr, 0);
        check("rst_a0", sl811_a0, 0);
        check("rst_bd_out", bd_out, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        step();

        // r0 write to W5300 addr 0x2A5 data 0x5C; this is cycle 0
        r0_req = 1; r0_rnw = 0; r0_tgt = 0; r0_addr = 10'h2A5; r0_wdata = 8'h5C;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("wr_cs_n", w5300_cs_n, !(n >= 1 && n <= 7));
            check("wr_bwr_n", bwr_n, !(n >= 3 && n <= 6));
            check("wr_brd_n", brd_n, 1);
            check("wr_bd_oe", bd_oe, (n <= 7));
            check("wr_r0_ack", r0_ack, (n == 7));
            check("wr_r1_ack", r1_ack, 0);
            check("wr_sl_cs_n", sl811_cs_n, 1);
            check("wr_busy", busy, (n <= 7));
            if (n <= 7) begin
                check("wr_bd_out", bd_out, 8'h5C);
                check("wr_addr", w5300_addr, 10'h2A5);
            end
            if (n == 8) r0_req = 0;
        end

        // r1 read from SL811 a0=1, bd_in=0xA7; cycle 8 above is cycle 0 here
        r1_req = 1; r1_rnw = 1; r1_tgt = 1; r1_addr = 10'h001; bd_in = 8'hA7;
        for (int n = 1; n <= 7; n++) begin
            step();
            check("rd_sl_cs_n", sl811_cs_n, !(n <= 6));
            check("rd_w_cs_n", w5300_cs_n, 1);
            check("rd_brd_n", brd_n, !(n >= 3 && n <= 5));
            check("rd_bwr_n", bwr_n, 1);
            check("rd_bd_oe", bd_oe, 0);
            check("rd_r1_ack", r1_ack, (n == 6));
            check("rd_r0_ack", r0_ack, 0);
            if (n <= 6) check("rd_a0", sl811_a0, 1);
            if (n == 6) check("rd_rdata", rdata, 8'hA7);
            if (n == 7) r1_req = 0;
        end
        check("rd_rdata_held", rdata, 8'hA7);

        // Both held: r0 (W5300 write) then r1 (SL811 write) then r0 again
        r0_req = 1; r0_rnw = 0; r0_tgt = 0; r0_addr = 10'h111; r0_wdata = 8'h11;
        r1_req = 1; r1_rnw = 0; r1_tgt = 1; r1_addr = 10'h000; r1_wdata = 8'h22;
        for (int n = 1; n <= 23; n++) begin
            step();
            check("rr_r0_ack", r0_ack, (n == 7 || n == 22));
            check("rr_r1_ack", r1_ack, (n == 14));
            check("rr_busy", busy, !(n == 8 || n == 15 || n == 23));
            check("rr_w_cs_n", w5300_cs_n, !((n >= 1 && n <= 7) || (n >= 16 && n <= 22)));
            check("rr_sl_cs_n", sl811_cs_n, !(n >= 9 && n <= 14));
            if (n == 10) check("rr_bd_out_r1", bd_out, 8'h22);
            if (n == 17) check("rr_bd_out_r0", bd_out, 8'h11);
            if (n == 23) begin
                r0_req = 0;
                r1_req = 0;
            end
        end

        // Reset during the second strobe cycle (cycle 4) of a W5300 read
        r0_req = 1; r0_rnw = 1; r0_tgt = 0; r0_addr = 10'h033; bd_in = 8'h99;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n == 3) check("ab_brd_pre", brd_n, 0);
            if (n == 4) rst = 1;
            if (n == 5) begin
                check("ab_brd_n", brd_n, 1);
                check("ab_cs_n", w5300_cs_n, 1);
                check("ab_busy", busy, 0);
                rst = 0;
                r0_req = 0;
            end
            if (n >= 5) check("ab_no_ack", r0_ack, 0);
        end

        // Fresh r1 W5300 write with default timing
        r1_req = 1; r1_rnw = 0; r1_tgt = 0; r1_addr = 10'h155; r1_wdata = 8'h3C;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("fr_cs_n", w5300_cs_n, !(n <= 7));
            check("fr_bwr_n", bwr_n, !(n >= 3 && n <= 6));
            check("fr_r1_ack", r1_ack, (n == 7));
            check("fr_r0_ack", r0_ack, 0);
            if (n == 4) begin
                check("fr_bd_out", bd_out, 8'h3C);
                check("fr_addr", w5300_addr, 10'h155);
            end
            if (n == 8) r1_req = 0;
        end

        // Short-timing build: wait until both sequencers are idle
        guard = 0;
        while ((busy || b_busy) && guard < 50) begin
            step();
            guard++;
        end
        check("idle_timeout", (guard < 50), 1);
        step();

        r0_req = 1; r0_rnw = 0; r0_tgt = 0; r0_addr = 10'h0F0; r0_wdata = 8'hE1;
        for (int n = 1; n <= 5; n++) begin
            step();
            in_rng = (n >= 1 && n <= 3);
            check("sh_bwr_n", b_bwr_n, !(n == 2));
            check("sh_r0_ack", b_r0_ack, (n == 3));
            check("sh_busy", b_busy, in_rng);
            check("sh_cs_n", b_w5300_cs_n, !in_rng);
            if (n == 4) r0_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
